// File: rtl/usr_pkg.sv
// usr_pkg: shared debounce FSM encodings and default cycle constants
package usr_pkg;

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        CHK_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        CHK_RELEASE = 2'd3
    } db_state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_REPEAT_DELAY    = 50_000_000;
    localparam int DEF_REPEAT_RATE     = 10_000_000;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous board input
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1_d, s1_q, s2_d, s2_q;

    // shift the raw level through two flops
    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    // synchroniser flops, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/switch_debounce_step.sv
// switch_debounce_step: debounced switch with press/release/repeat pulses and STEP strobe
module switch_debounce_step
    import usr_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic CLK,
    input  logic RST,
    input  logic SWITCH,
    output logic DEBOUNCED,
    output logic PRESS_PULSE,
    output logic RELEASE_PULSE,
    output logic REPEAT_PULSE,
    output logic STEP
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW = $clog2(max2(max2(REPEAT_DELAY, REPEAT_RATE), 1) + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] REP_DELAY = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] REP_RATE = RW'(REPEAT_RATE);
    localparam bit REP_EN = REPEAT_DELAY > 0;

    logic s2;
    db_state_e state_d, state_q;
    logic [CW-1:0] cnt_d, cnt_q;
    logic [RW-1:0] rep_cnt_d, rep_cnt_q;
    logic rep_first_d, rep_first_q;
    logic rep_fire;
    logic deb_d, deb_q, press_d, press_q, release_d, release_q, repeat_d, repeat_q, step_d, step_q;

    sync_2ff u_sync (
        .clk(CLK),
        .rst(RST),
        .d  (SWITCH),
        .q  (s2)
    );

    // debounce FSM: a change is accepted only after DEBOUNCE_CYCLES stable samples
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RELEASED: if (s2) begin
                state_d = CHK_PRESS;
                cnt_d   = '0;
            end
            CHK_PRESS:
                if (!s2) state_d = RELEASED;
                else if (cnt_q == CNT_LAST) state_d = PRESSED;
                else cnt_d = cnt_q + 1'b1;
            PRESSED: if (!s2) begin
                state_d = CHK_RELEASE;
                cnt_d   = '0;
            end
            CHK_RELEASE:
                if (s2) state_d = PRESSED;
                else if (cnt_q == CNT_LAST) state_d = RELEASED;
                else cnt_d = cnt_q + 1'b1;
            default: state_d = RELEASED;
        endcase
    end

    // FSM state and debounce counter
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rep_fire = REP_EN && state_q == PRESSED && rep_cnt_q == (rep_first_q ? REP_DELAY : REP_RATE);

    // hold-repeat counter: counts only in PRESSED, so a release bounce just pauses the cadence
    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
        if (state_q == CHK_PRESS && state_d == PRESSED) begin
            rep_cnt_d   = '0;
            rep_first_d = 1'b1;
        end else if (state_q == CHK_RELEASE && state_d == RELEASED) begin
            rep_cnt_d = '0;
        end else if (rep_fire) begin
            rep_cnt_d   = RW'(1);
            rep_first_d = 1'b0;
        end else if (REP_EN && state_q == PRESSED) begin
            rep_cnt_d = rep_cnt_q + 1'b1;
        end
    end

    // repeat counter registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
        end
    end

    // output decode: edges are detected as the registered level lagging the FSM state
    always_comb begin
        deb_d     = state_q == PRESSED || state_q == CHK_RELEASE;
        press_d   = state_q == PRESSED && !deb_q;
        release_d = state_q == RELEASED && deb_q;
        repeat_d  = rep_fire;
        step_d    = press_d | rep_fire;
    end

    // registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            deb_q     <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            deb_q     <= deb_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
            step_q    <= step_d;
        end
    end

    assign DEBOUNCED     = deb_q;
    assign PRESS_PULSE   = press_q;
    assign RELEASE_PULSE = release_q;
    assign REPEAT_PULSE  = repeat_q;
    assign STEP          = step_q;

endmodule
